// File: rtl/cam_pkg.sv
// Shared constants and types for the OV7670 capture path: QVGA geometry, frame buffer depth,
// RGB565 field positions and the capture state encoding.
package cam_pkg;

    localparam int unsigned QVGA_W   = 320;
    localparam int unsigned QVGA_H   = 240;
    localparam int unsigned FB_DEPTH = QVGA_W * QVGA_H;

    localparam int unsigned RGB_R_HI = 15;
    localparam int unsigned RGB_R_LO = 11;
    localparam int unsigned RGB_G_HI = 10;
    localparam int unsigned RGB_G_LO = 5;
    localparam int unsigned RGB_B_HI = 4;
    localparam int unsigned RGB_B_LO = 0;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ARMED   = 2'd1,
        ACTIVE  = 2'd2
    } cap_state_t;

    // Number of words one frame may occupy in the buffer; elaboration-time only.
    function automatic int unsigned fb_limit(input int unsigned w, input int unsigned h,
                                             input bit decim);
        return decim ? ((w * h) >> 2) : (w * h);
    endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Registers the raw camera bus, detects href falling edges and pairs bytes into RGB565 words.
// pixel_valid strobes in the cycle the second byte of a pair sits in the input register.
module ov7670_byte_pair (
    input  logic        pclk,
    input  logic        rst,
    input  logic        clr,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic        vsync_s,
    output logic        href_fall,
    output logic        pixel_valid,
    output logic        phase,
    output logic [15:0] word
);

    logic       href_q;
    logic       href_prev_q;
    logic       vsync_q;
    logic       phase_q;
    logic [7:0] d_q;
    logic [7:0] hi_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            href_q      <= 1'b0;
            href_prev_q <= 1'b0;
            vsync_q     <= 1'b0;
            phase_q     <= 1'b0;
            d_q         <= 8'd0;
            hi_q        <= 8'd0;
        end else begin
            href_q      <= href;
            href_prev_q <= href_q;
            vsync_q     <= vsync;
            d_q         <= d;
            // Phase holds its last value through the href-fall cycle so the top can spot odd lines.
            if (clr || !href_q) begin
                phase_q <= 1'b0;
            end else begin
                phase_q <= ~phase_q;
            end
            if (href_q && !phase_q && !clr) begin
                hi_q <= d_q;
            end
        end
    end

    assign href_fall   = href_prev_q & ~href_q;
    assign pixel_valid = href_q & phase_q & ~clr;
    assign phase       = phase_q;
    assign word        = {hi_q, d_q};
    assign vsync_s     = vsync_q;

endmodule

// File: rtl/ov7670_capture_qvga.sv
// OV7670 capture stage: frame-synchronised RGB565 capture with optional 2:1 decimation, writing
// linearly into the frame buffer, with per-line geometry checking and a completed-frame counter.
module ov7670_capture_qvga
    import cam_pkg::*;
#(
    parameter int unsigned SRC_W  = 640,
    parameter int unsigned SRC_H  = 480,
    parameter int unsigned DECIM  = 1,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              line_err,
    output logic [7:0]        frame_cnt
);

    localparam int          CNT_W    = 16;
    localparam int unsigned LIMIT    = fb_limit(SRC_W, SRC_H, DECIM != 0);
    localparam logic [CNT_W-1:0] COL_FULL = CNT_W'(SRC_W);
    localparam logic [CNT_W-1:0] ROW_FULL = CNT_W'(SRC_H);

    cap_state_t state_q, state_d;

    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic        clr;
    logic        vsync_s;
    logic        href_fall;
    logic        pixel_valid;
    logic        phase;
    logic [15:0] word;
    logic        keep;
    logic        in_range;

    // Byte phase is held cleared outside active capture and on the vsync that ends a frame,
    // so an abandoned line can never complete a pixel.
    assign clr = (state_q != ACTIVE) || vsync_s;

    ov7670_byte_pair u_pair (
        .pclk        (pclk),
        .rst         (rst),
        .clr         (clr),
        .vsync       (vsync),
        .href        (href),
        .d           (d),
        .vsync_s     (vsync_s),
        .href_fall   (href_fall),
        .pixel_valid (pixel_valid),
        .phase       (phase),
        .word        (word)
    );

    assign keep     = (DECIM == 0) || (!col_q[0] && !row_q[0]);
    assign in_range = 32'(wptr_q) < LIMIT;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        wptr_d       = wptr_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        frame_cnt_d  = frame_cnt_q;

        unique case (state_q)
            WAIT_VS: begin
                if (vsync_s) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                col_d      = '0;
                row_d      = '0;
                wptr_d     = '0;
                line_err_d = 1'b0;
                if (!vsync_s) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vsync_s) begin
                    state_d = ARMED;
                    if (row_q == ROW_FULL && !line_err_q) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                    end
                end else if (pixel_valid) begin
                    col_d = col_q + CNT_W'(1);
                    if (keep && in_range) begin
                        we_d   = 1'b1;
                        addr_d = wptr_q;
                        dout_d = word;
                        wptr_d = wptr_q + ADDR_W'(1);
                    end
                end else if (href_fall) begin
                    col_d = '0;
                    row_d = row_q + CNT_W'(1);
                    if (phase || col_q != COL_FULL || row_q >= ROW_FULL) begin
                        line_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = WAIT_VS;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_VS;
            col_q        <= '0;
            row_q        <= '0;
            wptr_q       <= '0;
            addr_q       <= '0;
            dout_q       <= 16'd0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wptr_q       <= wptr_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_capture_qvga.sv
// Scoreboard bench: an 8x6 decimating instance (12-word buffer) and a 4x2 pass-through instance
// share one stimulus bus, steered by sel; a negedge monitor checks every write against a queue.
module tb_ov7670_capture_qvga;

    localparam int LIM_A = 12;

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic       sel  = 1'b0;
    logic       v    = 1'b0;
    logic       h    = 1'b0;
    logic [7:0] dd   = 8'd0;

    always #5 pclk = ~pclk;

    logic        vs_a, hr_a, vs_b, hr_b;
    logic [7:0]  d_a, d_b;
    logic [16:0] addr_a, addr_b;
    logic [15:0] dout_a, dout_b;
    logic        we_a, we_b, fd_a, fd_b, le_a, le_b;
    logic [7:0]  fc_a, fc_b;
    logic        fd_s, le_s;
    logic [7:0]  fc_s;

    assign vs_a = sel ? 1'b0 : v;
    assign hr_a = sel ? 1'b0 : h;
    assign d_a  = sel ? 8'd0 : dd;
    assign vs_b = sel ? v : 1'b0;
    assign hr_b = sel ? h : 1'b0;
    assign d_b  = sel ? dd : 8'd0;
    assign fd_s = sel ? fd_b : fd_a;
    assign le_s = sel ? le_b : le_a;
    assign fc_s = sel ? fc_b : fc_a;

    ov7670_capture_qvga #(.SRC_W(8), .SRC_H(6), .DECIM(1), .ADDR_W(17)) dut_a (
        .pclk(pclk), .rst(rst), .vsync(vs_a), .href(hr_a), .d(d_a),
        .addr(addr_a), .dout(dout_a), .we(we_a), .frame_done(fd_a),
        .line_err(le_a), .frame_cnt(fc_a)
    );

    ov7670_capture_qvga #(.SRC_W(4), .SRC_H(2), .DECIM(0), .ADDR_W(17)) dut_b (
        .pclk(pclk), .rst(rst), .vsync(vs_b), .href(hr_b), .d(d_b),
        .addr(addr_b), .dout(dout_b), .we(we_b), .frame_done(fd_b),
        .line_err(le_b), .frame_cnt(fc_b)
    );

    typedef struct packed {
        logic [16:0] a;
        logic [15:0] w;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source pixel word; instance B's very first pixel is the 0xAB,0xCD vector.
    function automatic logic [15:0] pix(input int r, input int c);
        if (sel && r == 0 && c == 0) return 16'hABCD;
        return {8'(r * 16 + c), 8'h80 ^ 8'(c * 16 + r)};
    endfunction

    always @(negedge pclk) begin : monitor
        wr_t e;
        if (!rst) begin
            if (we_a) begin
                if (qa.size() == 0) begin
                    chk("we_a_unexpected", 32'(we_a), 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("addr_a", 32'(addr_a), 32'(e.a));
                    chk("dout_a", 32'(dout_a), 32'(e.w));
                end
            end
            if (we_b) begin
                if (qb.size() == 0) begin
                    chk("we_b_unexpected", 32'(we_b), 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("addr_b", 32'(addr_b), 32'(e.a));
                    chk("dout_b", 32'(dout_b), 32'(e.w));
                end
            end
        end
    end

    task automatic exp_a(input int r, input int ncols, inout int n);
        for (int c = 0; c < ncols; c += 2) begin
            if (n < LIM_A) begin
                qa.push_back({17'(n), pix(r, c)});
                n++;
            end
        end
    endtask

    task automatic send_line(input int r, input int nbytes);
        logic [15:0] w;
        for (int b = 0; b < nbytes; b++) begin
            w = pix(r, b / 2);
            @(negedge pclk);
            h  = 1'b1;
            dd = b[0] ? w[7:0] : w[15:8];
        end
        @(negedge pclk);
        h  = 1'b0;
        dd = 8'd0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic end_frame(input logic exp_fd, input logic [7:0] exp_cnt);
        @(negedge pclk);
        v = 1'b1;
        @(negedge pclk);
        chk("frame_done_early", 32'(fd_s), 32'd0);
        @(negedge pclk);
        chk("frame_done_pulse", 32'(fd_s), 32'(exp_fd));
        chk("frame_cnt", 32'(fc_s), 32'(exp_cnt));
        @(negedge pclk);
        chk("frame_done_late", 32'(fd_s), 32'd0);
        @(negedge pclk);
        v = 1'b0;
        repeat (3) @(negedge pclk);
        chk("line_err_cleared", 32'(le_s), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        logic [15:0] w;

        repeat (3) @(negedge pclk);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_dout", 32'(dout_a), 32'd0);
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_frame_done", 32'(fd_a), 32'd0);
        chk("rst_line_err", 32'(le_a), 32'd0);
        chk("rst_frame_cnt", 32'(fc_a), 32'd0);
        rst = 1'b0;

        // Mid-frame start: lines before any vsync must produce nothing.
        for (int r = 0; r < 3; r++) send_line(r, 16);
        end_frame(1'b0, 8'd0);

        // Complete frame: 12 writes, addr 5 = source (row 2, col 2).
        n = 0;
        for (int r = 0; r < 6; r += 2) exp_a(r, 8, n);
        for (int r = 0; r < 6; r++) send_line(r, 16);
        chk("line_err_good", 32'(le_a), 32'd0);
        end_frame(1'b1, 8'd1);
        chk("qa_drained_good", 32'(qa.size()), 32'd0);

        // Odd-length line 2: writes still land, frame rejected.
        n = 0;
        for (int r = 0; r < 6; r += 2) exp_a(r, 8, n);
        for (int r = 0; r < 6; r++) send_line(r, (r == 2) ? 15 : 16);
        chk("line_err_odd", 32'(le_a), 32'd1);
        end_frame(1'b0, 8'd1);
        chk("qa_drained_odd", 32'(qa.size()), 32'd0);

        // Two extra lines: writes saturate at addr 11, frame rejected.
        n = 0;
        for (int r = 0; r < 8; r += 2) exp_a(r, 8, n);
        for (int r = 0; r < 8; r++) send_line(r, 16);
        chk("line_err_tall", 32'(le_a), 32'd1);
        end_frame(1'b0, 8'd1);
        chk("qa_drained_tall", 32'(qa.size()), 32'd0);

        // vsync rises with the second byte of pixel 4 on row 4: that pixel must not be written.
        n = 0;
        exp_a(0, 8, n);
        exp_a(2, 8, n);
        exp_a(4, 4, n);
        for (int r = 0; r < 4; r++) send_line(r, 16);
        for (int b = 0; b < 12; b++) begin
            w = pix(4, b / 2);
            @(negedge pclk);
            h  = 1'b1;
            dd = b[0] ? w[7:0] : w[15:8];
            if (b == 9) v = 1'b1;
        end
        @(negedge pclk);
        h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("frame_done_abort", 32'(fd_a), 32'd0);
        end
        chk("frame_cnt_abort", 32'(fc_a), 32'd1);
        chk("qa_drained_abort", 32'(qa.size()), 32'd0);
        v = 1'b0;
        repeat (3) @(negedge pclk);

        // Recovery frame after the abort.
        n = 0;
        for (int r = 0; r < 6; r += 2) exp_a(r, 8, n);
        for (int r = 0; r < 6; r++) send_line(r, 16);
        end_frame(1'b1, 8'd2);
        chk("qa_drained_recover", 32'(qa.size()), 32'd0);

        // Pass-through 4x2 instance: 8 writes, first word 0xABCD.
        sel = 1'b1;
        end_frame(1'b0, 8'd0);
        n = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                qb.push_back({17'(n), pix(r, c)});
                n++;
            end
        end
        send_line(0, 8);
        send_line(1, 8);
        end_frame(1'b1, 8'd1);
        chk("qb_drained", 32'(qb.size()), 32'd0);

        repeat (4) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
